// File: rtl/sobel_stream_if.sv
// -----------------------------------------------------------------------------
// sobel_stream_if
// Bundles the FIFO-side handshake of the Sobel filter: the pop side of the
// grayscale input FIFO (first-word-fall-through) and the push side of the
// output FIFO.
//   master : filter side (drives rd_en, wr_en, din)
//   slave  : FIFO side   (drives dout, empty, full)
// Ports carried:
//   fifo_in_rd_en   pop input FIFO this cycle
//   fifo_in_dout    input pixel, valid while rd_en is high
//   fifo_in_empty   input FIFO empty
//   fifo_out_wr_en  push fifo_out_din this cycle
//   fifo_out_din    output pixel
//   fifo_out_full   output FIFO full
// -----------------------------------------------------------------------------
interface sobel_stream_if #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8
) ();
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;

  modport master (
    output fifo_in_rd_en, fifo_out_wr_en, fifo_out_din,
    input  fifo_in_dout, fifo_in_empty, fifo_out_full
  );

  modport slave (
    input  fifo_in_rd_en, fifo_out_wr_en, fifo_out_din,
    output fifo_in_dout, fifo_in_empty, fifo_out_full
  );
endinterface

// File: rtl/sobel_stream.sv
// -----------------------------------------------------------------------------
// sobel_stream
// Streaming 3x3 Sobel edge filter for raster-order grayscale pixels. Two line
// buffers plus a two-column window form the 3x3 neighbourhood; the incoming
// pixel supplies the right-hand column. One output pixel per input pixel;
// image-border centres produce 0. After the last pixel of a frame the
// remaining IMG_WIDTH+1 centres (all border) are flushed as zeros.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high
//   mode    00 (|Gx|+|Gy|)/2, 01 |Gx|, 10 |Gy|, 11 threshold on mode-00 value
//   thresh  threshold for mode 11
//   fifo    sobel_stream_if.master (input FIFO pop side, output FIFO push side)
// -----------------------------------------------------------------------------
module sobel_stream #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [DWIDTH_OUT-1:0] thresh,
  sobel_stream_if.master        fifo
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FW = $clog2(IMG_WIDTH + 1);
  localparam int GW = DWIDTH_IN + 4;
  localparam logic [DWIDTH_OUT-1:0] OUT_MAX = '1;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  // Zero-extend a pixel into the signed gradient width.
  function automatic logic signed [GW-1:0] ext(input logic [DWIDTH_IN-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // Magnitude of a signed gradient.
  function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] g);
    if (g[GW-1]) begin
      return $unsigned(-g);
    end else begin
      return $unsigned(g);
    end
  endfunction

  // Clamp an unsigned magnitude to the output range.
  function automatic logic [DWIDTH_OUT-1:0] sat(input logic [GW-1:0] v);
    if (v > GW'(OUT_MAX)) begin
      return OUT_MAX;
    end else begin
      return v[DWIDTH_OUT-1:0];
    end
  endfunction

  state_t                state_r;
  logic [XW-1:0]         x_cnt_r;
  logic [YW-1:0]         y_cnt_r;
  logic [FW-1:0]         flush_cnt_r;
  logic                  out_valid_r;
  logic [DWIDTH_OUT-1:0] out_data_r;
  logic [1:0]            mode_r;
  logic [DWIDTH_OUT-1:0] thresh_r;

  // Line buffers: top = two rows back, mid = one row back, indexed by column.
  logic [DWIDTH_IN-1:0] lb_top_r [IMG_WIDTH];
  logic [DWIDTH_IN-1:0] lb_mid_r [IMG_WIDTH];
  // Window columns (index 0 = top row, 2 = bottom row).
  logic [DWIDTH_IN-1:0] win_l_r [3];
  logic [DWIDTH_IN-1:0] win_m_r [3];

  logic                  advance_s;
  logic                  rd_en_s;
  logic                  last_pix_s;
  logic                  has_out_s;
  logic                  interior_s;
  logic [DWIDTH_IN-1:0]  col_s [3];
  logic signed [GW-1:0]  gx_s;
  logic signed [GW-1:0]  gy_s;
  logic [GW-1:0]         ax_s;
  logic [GW-1:0]         ay_s;
  logic [DWIDTH_OUT-1:0] mag_s;
  logic [DWIDTH_OUT-1:0] val_s;
  logic [DWIDTH_OUT-1:0] pix_s;

  assign advance_s           = ~out_valid_r | ~fifo.fifo_out_full;
  assign rd_en_s             = (state_r == RUN) & ~fifo.fifo_in_empty & advance_s;
  assign fifo.fifo_in_rd_en  = rd_en_s;
  assign fifo.fifo_out_wr_en = out_valid_r & ~fifo.fifo_out_full;
  assign fifo.fifo_out_din   = out_data_r;

  // Pixel position decode: the centre of the current read is one row and one
  // column behind it, so only reads with x>=2 and y>=2 have an interior centre.
  always_comb begin
    last_pix_s = (x_cnt_r == XW'(IMG_WIDTH - 1)) && (y_cnt_r == YW'(IMG_HEIGHT - 1));
    has_out_s  = (y_cnt_r > YW'(1)) || ((y_cnt_r == YW'(1)) && (x_cnt_r != XW'(0)));
    interior_s = (x_cnt_r >= XW'(2)) && (y_cnt_r >= YW'(2));
  end

  // Sobel arithmetic on the window plus the incoming right-hand column.
  always_comb begin
    col_s[0] = lb_top_r[x_cnt_r];
    col_s[1] = lb_mid_r[x_cnt_r];
    col_s[2] = fifo.fifo_in_dout;
    gx_s = (ext(col_s[0]) + (ext(col_s[1]) <<< 1) + ext(col_s[2]))
         - (ext(win_l_r[0]) + (ext(win_l_r[1]) <<< 1) + ext(win_l_r[2]));
    gy_s = (ext(win_l_r[2]) + (ext(win_m_r[2]) <<< 1) + ext(col_s[2]))
         - (ext(win_l_r[0]) + (ext(win_m_r[0]) <<< 1) + ext(col_s[0]));
    ax_s = abs_g(gx_s);
    ay_s = abs_g(gy_s);
    // floor((ax+ay)/2) without widening past GW bits
    mag_s = sat((ax_s >> 1) + (ay_s >> 1) + GW'(ax_s[0] & ay_s[0]));
    case (mode_r)
      2'b00:   val_s = mag_s;
      2'b01:   val_s = sat(ax_s);
      2'b10:   val_s = sat(ay_s);
      2'b11:   val_s = (mag_s >= thresh_r) ? OUT_MAX : {DWIDTH_OUT{1'b0}};
      default: val_s = {DWIDTH_OUT{1'b0}};
    endcase
    if (interior_s) begin
      pix_s = val_s;
    end else begin
      pix_s = {DWIDTH_OUT{1'b0}};
    end
  end

  // Line buffer update; contents need no reset because every interior centre
  // only uses rows already written in the current frame.
  always_ff @(posedge clock) begin
    if (rd_en_s) begin
      lb_top_r[x_cnt_r] <= lb_mid_r[x_cnt_r];
      lb_mid_r[x_cnt_r] <= fifo.fifo_in_dout;
    end
  end

  // Control FSM, window, counters and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= RUN;
      x_cnt_r     <= '0;
      y_cnt_r     <= '0;
      flush_cnt_r <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      mode_r      <= 2'b00;
      thresh_r    <= '0;
      for (int i = 0; i < 3; i++) begin
        win_l_r[i] <= '0;
        win_m_r[i] <= '0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (rd_en_s) begin
            for (int i = 0; i < 3; i++) begin
              win_l_r[i] <= win_m_r[i];
              win_m_r[i] <= col_s[i];
            end
            if ((x_cnt_r == XW'(0)) && (y_cnt_r == YW'(0))) begin
              mode_r   <= mode;
              thresh_r <= thresh;
            end
            out_valid_r <= has_out_s;
            if (has_out_s) begin
              out_data_r <= pix_s;
            end
            if (last_pix_s) begin
              x_cnt_r <= '0;
              y_cnt_r <= '0;
              state_r <= FLUSH;
            end else if (x_cnt_r == XW'(IMG_WIDTH - 1)) begin
              x_cnt_r <= '0;
              y_cnt_r <= y_cnt_r + YW'(1);
            end else begin
              x_cnt_r <= x_cnt_r + XW'(1);
            end
          end else if (advance_s) begin
            out_valid_r <= 1'b0;
          end
        end
        FLUSH: begin
          if (advance_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= '0;
            if (flush_cnt_r == FW'(IMG_WIDTH)) begin
              flush_cnt_r <= '0;
              state_r     <= RUN;
            end else begin
              flush_cnt_r <= flush_cnt_r + FW'(1);
            end
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

  typedef struct {
    logic [7:0] left;     // value of columns 0,1 (or rows 0,1 if rows=1)
    logic [7:0] right;    // value of columns 2,3 (or rows 2,3)
    logic       rows;
    logic [1:0] mode;
    logic [7:0] thresh;
    logic [7:0] exp_int;  // expected value at the four interior centres
    logic       gaps;
    logic       bp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] thresh = 8'd0;

  sobel_stream_if #(.DWIDTH_IN(8), .DWIDTH_OUT(8)) sif ();

  sobel_stream #(
    .IMG_WIDTH(4), .IMG_HEIGHT(4), .DWIDTH_IN(8), .DWIDTH_OUT(8)
  ) dut (
    .clock(clk), .reset(reset), .mode(mode), .thresh(thresh), .fifo(sif)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  logic       gap_en = 1'b0;
  logic       full_force = 1'b0;
  int         rd_total = 0;
  int         wr_total = 0;
  int         rd_in_full = 0;
  int         first_wr = -1;
  int         frame_rd_base = 0;
  vec_t       tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO models and output scoreboard: inputs change at negedge, handshakes
  // are sampled 1 time unit later and take effect at the next posedge.
  always @(negedge clk) begin
    logic [7:0] e;
    sif.fifo_out_full = full_force;
    sif.fifo_in_empty = (in_q.size() == 0) || (gap_en && ($urandom_range(0, 3) == 0));
    sif.fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 8'd0;
    #1;
    if (sif.fifo_out_wr_en) begin
      if (first_wr < 0) first_wr = rd_total - frame_rd_base;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(sif.fifo_out_din), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 32'(sif.fifo_out_din), 32'(e));
      end
      wr_total++;
    end
    if (sif.fifo_in_rd_en) begin
      if (sif.fifo_in_empty) begin
        check("read_while_empty", 32'(1), 32'(0));
      end else begin
        void'(in_q.pop_front());
      end
      rd_total++;
      if (sif.fifo_out_full) rd_in_full++;
    end
  end

  task automatic push_frame(input vec_t v, input int npix);
    for (int n = 0; n < npix; n++) begin
      int x = n % 4;
      int y = n / 4;
      logic [7:0] p;
      if (v.rows) p = (y >= 2) ? v.right : v.left;
      else        p = (x >= 2) ? v.right : v.left;
      in_q.push_back(p);
      exp_q.push_back((x >= 1 && x <= 2 && y >= 1 && y <= 2) ? v.exp_int : 8'd0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int cnt = 0;
    int wr_base;
    mode = v.mode;
    thresh = v.thresh;
    gap_en = v.gaps;
    first_wr = -1;
    frame_rd_base = rd_total;
    wr_base = wr_total;
    push_frame(v, 16);
    while (in_q.size() > 10 && cnt < 1000) begin @(negedge clk); cnt++; end
    // mid-frame mode/thresh changes must not affect this frame
    mode = v.mode ^ 2'b11;
    thresh = ~v.thresh;
    if (v.bp) begin
      while (in_q.size() > 8 && cnt < 1000) begin @(negedge clk); cnt++; end
      full_force = 1'b1;
      rd_in_full = 0;
      repeat (10) @(negedge clk);
      full_force = 1'b0;
      check("reads_while_full", 32'(rd_in_full <= 1), 32'(1));
    end
    while ((exp_q.size() != 0 || in_q.size() != 0) && cnt < 1000) begin
      @(negedge clk); cnt++;
    end
    check("frame_timeout", 32'(cnt < 1000), 32'(1));
    repeat (4) @(negedge clk);
    check("writes_per_frame", 32'(wr_total - wr_base), 32'(16));
    check("first_write_read_count", 32'(first_wr), 32'(6));
    gap_en = 1'b0;
    in_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    int base;
    sif.fifo_in_empty = 1'b1;
    sif.fifo_in_dout  = 8'd0;
    sif.fifo_out_full = 1'b0;

    //           left    right   rows  mode   thresh  exp     gaps  bp
    tbl[0]  = '{8'd100, 8'd100, 1'b0, 2'b00, 8'd0,   8'd0,   1'b0, 1'b0};
    tbl[1]  = '{8'd0,   8'd40,  1'b0, 2'b00, 8'd0,   8'd80,  1'b0, 1'b0};
    tbl[2]  = '{8'd0,   8'd40,  1'b0, 2'b01, 8'd0,   8'd160, 1'b0, 1'b0};
    tbl[3]  = '{8'd0,   8'd40,  1'b0, 2'b10, 8'd0,   8'd0,   1'b0, 1'b0};
    tbl[4]  = '{8'd0,   8'd40,  1'b0, 2'b11, 8'd80,  8'd255, 1'b0, 1'b0};
    tbl[5]  = '{8'd0,   8'd40,  1'b0, 2'b11, 8'd81,  8'd0,   1'b0, 1'b0};
    tbl[6]  = '{8'd0,   8'd255, 1'b0, 2'b01, 8'd0,   8'd255, 1'b0, 1'b0};
    tbl[7]  = '{8'd0,   8'd255, 1'b0, 2'b00, 8'd0,   8'd255, 1'b0, 1'b0};
    tbl[8]  = '{8'd0,   8'd40,  1'b1, 2'b10, 8'd0,   8'd160, 1'b0, 1'b0};
    tbl[9]  = '{8'd0,   8'd40,  1'b1, 2'b00, 8'd0,   8'd80,  1'b0, 1'b0};
    tbl[10] = '{8'd0,   8'd40,  1'b0, 2'b00, 8'd0,   8'd80,  1'b1, 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("reset_rd_en", 32'(sif.fifo_in_rd_en), 32'(0));
    check("reset_wr_en", 32'(sif.fifo_out_wr_en), 32'(0));
    check("reset_din", 32'(sif.fifo_out_din), 32'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i]);
    end

    // reset after 9 reads aborts the frame; two clean frames follow
    mode = 2'b00;
    thresh = 8'd0;
    push_frame(tbl[1], 9);
    cnt = 0;
    while (in_q.size() != 0 && cnt < 200) begin @(negedge clk); cnt++; end
    check("partial_frame_timeout", 32'(cnt < 200), 32'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    in_q.delete();
    exp_q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    base = wr_total;
    run_frame(tbl[1]);
    run_frame(tbl[1]);
    check("writes_after_reset", 32'(wr_total - base), 32'(32));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
